// File: rtl/tc_pulse_pkg.sv
// Shared types and helpers for the pulse stretcher slice.
package tc_pulse_pkg;

    typedef enum logic [1:0] {IDLE, STRETCH, HOLD} pulse_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tc_edge_detect.sv
// Registers the previous input level and exposes combinational edge terms.
module tc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic re,
    output logic fe
);

    logic prev;

    // prev clears on reset, so a level held high through release looks like a rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= in;
    end

    assign re = in & ~prev;
    assign fe = ~in & prev;

endmodule

// File: rtl/tc_pulse_stretcher.sv
// Turns accepted rising edges into STRETCH-cycle pulses followed by a HOLDOFF window.
module tc_pulse_stretcher
    import tc_pulse_pkg::*;
#(
    parameter int STRETCH = 4,
    parameter int HOLDOFF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy,
    output logic overrun
);

    // The STRETCH parameter shadows the enum literal, so refer to states through aliases.
    localparam pulse_state_t ST_IDLE    = tc_pulse_pkg::IDLE;
    localparam pulse_state_t ST_STRETCH = tc_pulse_pkg::STRETCH;
    localparam pulse_state_t ST_HOLD    = tc_pulse_pkg::HOLD;

    localparam int CW = $clog2(max(STRETCH, HOLDOFF) + 1);
    localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH - 1);
    localparam logic [CW-1:0] HOLD_LD    = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    generate
        if (STRETCH < 1 || HOLDOFF < 0) begin : g_bad_param
            $error("tc_pulse_stretcher: STRETCH must be >= 1 and HOLDOFF >= 0");
        end
    endgenerate

    logic re, fe;

    tc_edge_detect u_edge (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .re  (re),
        .fe  (fe)
    );

    pulse_state_t  state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (re) begin
                    state_nx = ST_STRETCH;
                    cnt_nx   = STRETCH_LD;
                end
            end
            ST_STRETCH: begin
                if (cnt == '0) begin
                    if (HOLDOFF > 0) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = HOLD_LD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - CW'(1);
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs reflect the state being entered, so out rises on the same edge that accepts re.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            out     <= (state_nx == ST_STRETCH);
            busy    <= (state_nx != ST_IDLE);
            rise    <= re;
            fall    <= fe;
            overrun <= re & (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tc_pulse_stretcher.sv
// Random and directed stimulus against a cycle-count reference model, two parameter sets.
module tb_tc_pulse_stretcher;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in  = 1'b0;
    logic [NDUT-1:0] out, rise, fall, busy, ovr;

    always #5 clk = ~clk;

    tc_pulse_stretcher #(.STRETCH(4), .HOLDOFF(2)) u_d0 (
        .clk(clk), .rst(rst), .in(in),
        .out(out[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    tc_pulse_stretcher #(.STRETCH(1), .HOLDOFF(0)) u_d1 (
        .clk(clk), .rst(rst), .in(in),
        .out(out[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: pulse timing derived from the cycle index of the last accepted edge
    int         sw [NDUT];
    int         hw [NDUT];
    int         start [NDUT];
    bit         have [NDUT];
    bit         prev_m;
    int         n;
    logic [4:0] exp_v [NDUT];

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b (out,busy,rise,fall,ovr)", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        prev_m = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            have[d]  = 1'b0;
            exp_v[d] = '0;
        end
    endtask

    task automatic model_tick();
        bit re, fe, acc;
        int age;
        if (!rst) begin
            model_clear();
        end else begin
            re = in && !prev_m;
            fe = !in && prev_m;
            for (int d = 0; d < NDUT; d++) begin
                acc = re && (!have[d] || (n - start[d]) > sw[d] + hw[d]);
                if (acc) begin
                    have[d]  = 1'b1;
                    start[d] = n;
                end
                age = n - start[d];
                exp_v[d] = {have[d] && age < sw[d],
                            have[d] && age < sw[d] + hw[d],
                            re, fe, re && !acc};
            end
            prev_m = in;
        end
        n++;
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("%s d%0d c%0d", tag, d, n),
                {out[d], busy[d], rise[d], fall[d], ovr[d]}, exp_v[d]);
    endtask

    task automatic step(input string tag, input logic v, input logic r);
        @(negedge clk);
        in  = v;
        rst = r;
        @(posedge clk);
        #1;
        model_tick();
        check_all(tag);
    endtask

    // asynchronous reset asserted between edges; outputs must drop before the next posedge
    task automatic abort(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_all(tag);
    endtask

    initial begin
        logic [6:0] pat;
        int dens;
        sw[0] = 4; hw[0] = 2;
        sw[1] = 1; hw[1] = 0;
        n = 0;
        model_clear();
        for (int d = 0; d < NDUT; d++) start[d] = 0;

        for (int i = 0; i < 5; i++) step("rst_hold", logic'(i & 1), 1'b0);
        for (int i = 0; i < 4; i++) step("rst_rel", 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) step("single", 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)  step("single_lo", 1'b0, 1'b1);

        step("short", 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step("short_lo", 1'b0, 1'b1);

        // edges at k, k+3, k+6
        pat = 7'b1001001;
        for (int i = 6; i >= 0; i--) step("retrig", pat[i], 1'b1);
        for (int i = 0; i < 8; i++)  step("retrig_lo", 1'b0, 1'b1);
        // edges at k and k+7
        pat = 7'b1000000;
        for (int i = 6; i >= 0; i--) step("retrig7", pat[i], 1'b1);
        for (int i = 0; i < 8; i++)  step("retrig7_b", logic'(i == 0), 1'b1);

        for (int i = 0; i < 20; i++) step("toggle", logic'(~i & 1), 1'b1);
        for (int i = 0; i < 4; i++)  step("toggle_lo", 1'b0, 1'b1);

        step("abort_a", 1'b1, 1'b1);
        step("abort_a", 1'b1, 1'b1);
        abort("abort_a_async");
        step("abort_a_rst", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("abort_a_rel", 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step("abort_b", 1'b0, 1'b1);
        step("abort_b", 1'b1, 1'b1);
        step("abort_b", 1'b1, 1'b1);
        abort("abort_b_async");
        step("abort_b_rst", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("abort_b_rel", 1'b0, 1'b1);

        dens = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) dens = int'($urandom_range(5, 95));
            step("rand", logic'($urandom_range(0, 99) < dens),
                 logic'($urandom_range(0, 149) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
